spi_ram: RTL and testbench

Single-port byte memory downstream of the SPI slave. Consumes the slave's 10-bit command words (`rx_data`/`rx_valid`) and executes four commands: write-address, write-data, read-address and read-data. Returns the read byte on `tx_data`/`tx_valid` for the slave to shift out on MISO. Sequencing errors (for example, read-data with no armed read address) are flagged, not executed.

---
 rtl/spi_ram_pkg.sv | 21 ++
 rtl/spi_ram_if.sv | 17 +
 rtl/spi_ram_core.sv | 35 +++
 rtl/spi_ram.sv | 118 +++++++++++
 tb/tb_spi_ram.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared definitions for the SPI-attached byte RAM.
//   - 2-bit command encodings carried in rx_data[9:8]
//   - control FSM state type
//   - default geometry (MEM_DEPTH / ADDR_SIZE)
package spi_ram_pkg;

  localparam int MEM_DEPTH_DEF = 256;
  localparam int ADDR_SIZE_DEF = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_ARMED = 2'd1,
    S_TX       = 2'd2
  } state_t;

endpackage

// File: rtl/spi_ram_if.sv
// spi_ram_if: command/response bundle between the SPI slave and spi_ram.
//   rx_data  [9:0] command word, [9:8] = command, [7:0] = payload
//   rx_valid       one-cycle strobe qualifying rx_data
//   tx_data  [7:0] read byte for MISO
//   tx_valid       high while a read byte is presented
//   cmd_err        one-cycle pulse on a rejected command
// slave modport is the RAM side, master modport is the SPI slave side.
interface spi_ram_if;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       cmd_err;

  modport slave  (input rx_data, rx_valid, output tx_data, tx_valid, cmd_err);
  modport master (output rx_data, rx_valid, input tx_data, tx_valid, cmd_err);
endinterface

// File: rtl/spi_ram_core.sv
// spi_ram_core: byte storage, one synchronous write port and one synchronous
// read port. Not reset; contents are undefined after power-up.
//   clk        clock
//   i_we       write enable (caller guarantees i_wr_addr is in range)
//   i_wr_addr  write address
//   i_wr_data  write byte
//   i_re       read enable (caller guarantees i_rd_addr is in range)
//   i_rd_addr  read address
//   o_rd_data  registered read byte, held until the next read
module spi_ram_core
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_SIZE-1:0] i_wr_addr,
  input  logic [7:0]           i_wr_data,
  input  logic                 i_re,
  input  logic [ADDR_SIZE-1:0] i_rd_addr,
  output logic [7:0]           o_rd_data
);

  logic [7:0] r_mem [MEM_DEPTH];
  logic [7:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
    if (i_re) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/spi_ram.sv
// spi_ram: command decoder, control FSM, address and output registers in
// front of spi_ram_core. Executes WR_ADDR / WR_DATA / RD_ADDR / RD_DATA words
// from the SPI slave and returns read bytes on tx_data/tx_valid.
//   clk    clock, all state on the rising edge
//   rst_n  asynchronous active-low reset (control state only, not memory)
//   bus    spi_ram_if.slave (rx_data, rx_valid in; tx_data, tx_valid, cmd_err out)
// Build option: define SPI_RAM_WR_AUTOINC_EN to post-increment wr_addr after
// every executed WR_DATA (wrapping at MEM_DEPTH-1).
//
// state       | meaning
// S_IDLE      | no read armed, no byte presented
// S_RD_ARMED  | read address latched, next RD_DATA returns a byte
// S_TX        | byte presented, tx_valid = 1 until the next accepted command
module spi_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  spi_ram_if.slave  bus
);

  state_t               r_state;
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic                 r_tx_valid;
  logic                 r_cmd_err;
  // selects core read data onto tx_data; cleared gives 0x00 (reset / out-of-range read)
  logic                 r_tx_sel;

  logic [1:0]           w_cmd;
  logic [ADDR_SIZE-1:0] w_pl_addr;
  logic                 w_armed;
  logic                 w_wr_in_range;
  logic                 w_rd_in_range;
  logic                 w_we;
  logic                 w_re;
  logic [7:0]           w_rd_data;

  assign w_cmd         = bus.rx_data[9:8];
  assign w_pl_addr     = bus.rx_data[ADDR_SIZE-1:0];
  assign w_armed       = (r_state == S_RD_ARMED);
  assign w_wr_in_range = (32'(r_wr_addr) < 32'(MEM_DEPTH));
  assign w_rd_in_range = (32'(r_rd_addr) < 32'(MEM_DEPTH));
  assign w_we = bus.rx_valid && (w_cmd == CMD_WR_DATA) && w_wr_in_range;
  assign w_re = bus.rx_valid && (w_cmd == CMD_RD_DATA) && w_armed && w_rd_in_range;

  spi_ram_core #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_core (
    .clk       (clk),
    .i_we      (w_we),
    .i_wr_addr (r_wr_addr),
    .i_wr_data (bus.rx_data[7:0]),
    .i_re      (w_re),
    .i_rd_addr (r_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_tx_valid <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_tx_sel   <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;
      if (bus.rx_valid) begin
        // any accepted command retires a presented byte; the command then
        // runs as if from S_IDLE (S_RD_ARMED is kept by WR_* below)
        r_tx_valid <= 1'b0;
        case (w_cmd)
          CMD_WR_ADDR: begin
            r_wr_addr <= w_pl_addr;
            if (r_state == S_TX) r_state <= S_IDLE;
          end
          CMD_WR_DATA: begin
            if (w_wr_in_range) begin
`ifdef SPI_RAM_WR_AUTOINC_EN
              r_wr_addr <= (32'(r_wr_addr) == 32'(MEM_DEPTH - 1)) ? '0
                                                                  : r_wr_addr + ADDR_SIZE'(1);
`endif
            end else begin
              r_cmd_err <= 1'b1;
            end
            if (r_state == S_TX) r_state <= S_IDLE;
          end
          CMD_RD_ADDR: begin
            r_rd_addr <= w_pl_addr;
            r_state   <= S_RD_ARMED;
          end
          CMD_RD_DATA: begin
            if (w_armed) begin
              r_state    <= S_TX;
              r_tx_valid <= 1'b1;
              r_tx_sel   <= w_rd_in_range;
              if (!w_rd_in_range) r_cmd_err <= 1'b1;
            end else begin
              r_state   <= S_IDLE;
              r_cmd_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.tx_data  = r_tx_sel ? w_rd_data : 8'h00;
  assign bus.tx_valid = r_tx_valid;
  assign bus.cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_spi_ram.sv
// tb_spi_ram: drives two spi_ram instances (MEM_DEPTH 256 and 200) with the
// same command stream and compares both against a behavioural model.
module tb_spi_ram;
  import spi_ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_ram_if u_if_a ();
  spi_ram_if u_if_b ();

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(u_if_a));
  spi_ram #(.MEM_DEPTH(200), .ADDR_SIZE(8)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(u_if_b));

  int n_vec = 0;
  int n_err = 0;

  // behavioural model, index 0 = depth 256, index 1 = depth 200
  int         depth [2] = '{256, 200};
  logic [7:0] m_mem [2][256];
  bit         m_known [2][256];
  int         m_wa [2];
  int         m_ra [2];
  bit         m_arm [2];
  bit         m_txv [2];
  bit         m_err [2];
  logic [7:0] m_txd [2];
  bit         m_txd_known [2];

  logic [7:0] obs_txd [2];
  logic       obs_txv [2];
  logic       obs_err [2];
  assign obs_txd[0] = u_if_a.tx_data;
  assign obs_txv[0] = u_if_a.tx_valid;
  assign obs_err[0] = u_if_a.cmd_err;
  assign obs_txd[1] = u_if_b.tx_data;
  assign obs_txv[1] = u_if_b.tx_valid;
  assign obs_err[1] = u_if_b.cmd_err;

  function automatic string nm(input int k);
    return (k == 0) ? "d256" : "d200";
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wa[k] = 0; m_ra[k] = 0; m_arm[k] = 0; m_txv[k] = 0; m_err[k] = 0;
      m_txd[k] = 8'h00; m_txd_known[k] = 1;
    end
  endtask

  task automatic model_step(input int k, input bit v, input bit [1:0] cmd, input bit [7:0] pl);
    m_err[k] = 0;
    if (v) begin
      m_txv[k] = 0;
      case (cmd)
        2'b00: m_wa[k] = int'(pl);
        2'b01: begin
          if (m_wa[k] < depth[k]) begin
            m_mem[k][m_wa[k]] = pl;
            m_known[k][m_wa[k]] = 1;
`ifdef SPI_RAM_WR_AUTOINC_EN
            m_wa[k] = (m_wa[k] + 1) % depth[k];
`endif
          end else m_err[k] = 1;
        end
        2'b10: begin m_ra[k] = int'(pl); m_arm[k] = 1; end
        default: begin
          if (!m_arm[k]) m_err[k] = 1;
          else begin
            m_arm[k] = 0;
            m_txv[k] = 1;
            if (m_ra[k] < depth[k]) begin
              m_txd[k] = m_mem[k][m_ra[k]];
              m_txd_known[k] = m_known[k][m_ra[k]];
            end else begin
              m_txd[k] = 8'h00; m_txd_known[k] = 1; m_err[k] = 1;
            end
          end
        end
      endcase
    end
  endtask

  task automatic drive(input bit v, input bit [1:0] cmd, input bit [7:0] pl);
    u_if_a.rx_valid = v; u_if_a.rx_data = {cmd, pl};
    u_if_b.rx_valid = v; u_if_b.rx_data = {cmd, pl};
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      chk({nm(k), "_txv"}, 8'(obs_txv[k]), 8'(m_txv[k]));
      chk({nm(k), "_err"}, 8'(obs_err[k]), 8'(m_err[k]));
      if (m_txv[k] && m_txd_known[k]) chk({nm(k), "_txd"}, obs_txd[k], m_txd[k]);
    end
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic cycle(input bit v, input bit [1:0] cmd, input bit [7:0] pl);
    drive(v, cmd, pl);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, v, cmd, pl);
    @(negedge clk);
    drive(1'b0, 2'b00, 8'h00);
    check_outputs();
  endtask

  initial begin
    bit [1:0] r_cmd;
    bit [7:0] r_pl;
    bit       r_v;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) m_known[k][a] = 0;
    drive(1'b0, 2'b00, 8'h00);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("rst_txd_a", obs_txd[0], 8'h00);
    chk("rst_txd_b", obs_txd[1], 8'h00);
    check_outputs();

    // basic write then read
    cycle(1, CMD_WR_ADDR, 8'h05);
    cycle(1, CMD_WR_DATA, 8'hA7);
    cycle(1, CMD_RD_ADDR, 8'h05);
    cycle(1, CMD_RD_DATA, 8'h00);
    chk("rd_a7_data", obs_txd[0], 8'hA7);
    chk("rd_a7_valid", 8'(obs_txv[0]), 8'h01);
    repeat (10) cycle(0, 2'b00, 8'h00);
    chk("rd_a7_hold", 8'(obs_txv[0]), 8'h01);
    cycle(1, CMD_WR_ADDR, 8'h00);
    chk("rd_a7_clear", 8'(obs_txv[0]), 8'h00);

    // unarmed read
    cycle(1, CMD_RD_DATA, 8'h00);
    chk("unarmed_err", 8'(obs_err[0]), 8'h01);
    chk("unarmed_txv", 8'(obs_txv[0]), 8'h00);
    cycle(0, 2'b00, 8'h00);
    chk("err_pulse", 8'(obs_err[0]), 8'h00);
    cycle(1, CMD_RD_ADDR, 8'h05);
    cycle(1, CMD_RD_DATA, 8'h00);
    cycle(1, CMD_RD_DATA, 8'h00);
    chk("second_rd_err", 8'(obs_err[0]), 8'h01);

    // write at top of address space, two writes
    cycle(1, CMD_WR_ADDR, 8'hFF);
    cycle(1, CMD_WR_DATA, 8'h11);
    chk("ff_wr_err_b", 8'(obs_err[1]), 8'h01);
    cycle(1, CMD_WR_DATA, 8'h22);
    cycle(1, CMD_RD_ADDR, 8'hFF);
    cycle(1, CMD_RD_DATA, 8'h00);
`ifdef SPI_RAM_WR_AUTOINC_EN
    chk("autoinc_ff", obs_txd[0], 8'h11);
`else
    chk("noinc_ff", obs_txd[0], 8'h22);
`endif
    chk("ff_rd_zero_b", obs_txd[1], 8'h00);
    chk("ff_rd_err_b", 8'(obs_err[1]), 8'h01);
    cycle(1, CMD_RD_ADDR, 8'h00);
    cycle(1, CMD_RD_DATA, 8'h00);
`ifdef SPI_RAM_WR_AUTOINC_EN
    chk("autoinc_wrap", obs_txd[0], 8'h22);
`endif

    // first out-of-range location for depth 200
    cycle(1, CMD_WR_ADDR, 8'hC8);
    cycle(1, CMD_WR_DATA, 8'h33);
    chk("c8_wr_err_b", 8'(obs_err[1]), 8'h01);
    cycle(1, CMD_RD_ADDR, 8'hC8);
    cycle(1, CMD_RD_DATA, 8'h00);
    chk("c8_rd_a", obs_txd[0], 8'h33);
    chk("c8_rd_b", obs_txd[1], 8'h00);
    chk("c8_txv_b", 8'(obs_txv[1]), 8'h01);

    // back-to-back words
    cycle(1, CMD_WR_ADDR, 8'h10);
    cycle(1, CMD_WR_DATA, 8'h5A);
    cycle(1, CMD_RD_ADDR, 8'h10);
    cycle(1, CMD_RD_DATA, 8'h00);
    chk("b2b_txv_hi", 8'(obs_txv[0]), 8'h01);
    chk("b2b_txd", obs_txd[1], 8'h5A);
    cycle(1, CMD_WR_ADDR, 8'h10);
    chk("b2b_txv_lo", 8'(obs_txv[0]), 8'h00);

    // reset while a byte is presented
    cycle(1, CMD_RD_ADDR, 8'h10);
    cycle(1, CMD_RD_DATA, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_txv_a", 8'(obs_txv[0]), 8'h00);
    chk("rst_mid_txd_a", obs_txd[0], 8'h00);
    chk("rst_mid_txv_b", 8'(obs_txv[1]), 8'h00);
    chk("rst_mid_txd_b", obs_txd[1], 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, CMD_RD_DATA, 8'h00);
    chk("rst_arm_lost", 8'(obs_err[0]), 8'h01);

    // randomized traffic, addresses biased near 0 and the depth-200 boundary
    repeat (400) begin
      r_v = ($urandom_range(0, 9) < 7);
      r_cmd = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: r_pl = 8'($urandom_range(0, 7));
        1: r_pl = 8'($urandom_range(196, 203));
        default: r_pl = 8'($urandom_range(0, 255));
      endcase
      cycle(r_v, r_cmd, r_pl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
